// File: rtl/branch_target_pipe.sv
// Two-stage next-PC / branch-target generator with valid/ready flow control.
// S1 forms PC+inc, the scaled branch offset and the jump field; S2 selects and holds the target.
module branch_target_pipe #(
    parameter int ADDR_W = 32,
    parameter int IMM_W  = 16,
    parameter int JIDX_W = 26,
    parameter int SHIFT  = 2,
    parameter int PC_INC = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_pc,
    input  logic [JIDX_W-1:0] in_imm,
    input  logic [1:0]        in_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_target,
    output logic [ADDR_W-1:0] out_pc_next,
    output logic              out_wrap,
    output logic              out_illegal
);
    localparam int JT_W = JIDX_W + SHIFT;

    localparam logic [1:0] MODE_BRANCH = 2'b00;
    localparam logic [1:0] MODE_JUMP   = 2'b01;
    localparam logic [1:0] MODE_SEQ    = 2'b10;

    function automatic logic signed [ADDR_W-1:0] scale_offset(input logic [IMM_W-1:0] imm);
        logic signed [ADDR_W-1:0] ext;
        ext = {{(ADDR_W-IMM_W){imm[IMM_W-1]}}, imm};
        return ext <<< SHIFT;
    endfunction

    // Returns {wrap, sum}. A negative offset wraps when the unsigned add does NOT carry.
    function automatic logic [ADDR_W:0] add_offset(input logic [ADDR_W-1:0]        base,
                                                   input logic signed [ADDR_W-1:0] off);
        logic [ADDR_W:0] raw;
        raw = {1'b0, base} + {1'b0, off};
        return {raw[ADDR_W] ^ off[ADDR_W-1], raw[ADDR_W-1:0]};
    endfunction

    logic s1_adv;
    logic s2_adv;
    logic accept_p0;
    logic vld_p1;
    logic vld_p2;

    assign s2_adv    = ~vld_p2 | out_ready;
    assign s1_adv    = ~vld_p1 | s2_adv;
    assign in_ready  = s1_adv;
    assign accept_p0 = in_valid & s1_adv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            if (s1_adv) vld_p1 <= in_valid;
            if (s2_adv) vld_p2 <= vld_p1;
        end
    end

    // ---- stage 0 -> 1: operand preparation ----
    logic [ADDR_W:0]          pcn_sum_p0;
    logic signed [ADDR_W-1:0] off_p0;
    logic [JT_W-1:0]          jt_p0;

    assign pcn_sum_p0 = {1'b0, in_pc} + (ADDR_W+1)'(PC_INC);
    assign off_p0     = scale_offset(in_imm[IMM_W-1:0]);
    assign jt_p0      = {in_imm, {SHIFT{1'b0}}};

    logic [ADDR_W-1:0]        pcn_p1;
    logic                     pcn_carry_p1;
    logic signed [ADDR_W-1:0] off_p1;
    logic [JT_W-1:0]          jt_p1;
    logic [1:0]               mode_p1;

    always_ff @(posedge clk) begin
        if (accept_p0) begin
            pcn_p1       <= pcn_sum_p0[ADDR_W-1:0];
            pcn_carry_p1 <= pcn_sum_p0[ADDR_W];
            off_p1       <= off_p0;
            jt_p1        <= jt_p0;
            mode_p1      <= in_mode;
        end
    end

    // ---- stage 1 -> 2: target selection ----
    logic [ADDR_W:0]   br_p1;
    logic [ADDR_W-1:0] target_p1;
    logic              wrap_p1;
    logic              illegal_p1;

    assign br_p1 = add_offset(pcn_p1, off_p1);

    always_comb begin
        target_p1  = pcn_p1;
        wrap_p1    = pcn_carry_p1;
        illegal_p1 = 1'b0;
        case (mode_p1)
            MODE_BRANCH: begin
                target_p1 = br_p1[ADDR_W-1:0];
                wrap_p1   = br_p1[ADDR_W];
            end
            MODE_JUMP: begin
                target_p1 = {pcn_p1[ADDR_W-1:JT_W], jt_p1};
                wrap_p1   = 1'b0;
            end
            MODE_SEQ: begin
                target_p1 = pcn_p1;
            end
            default: begin
                illegal_p1 = 1'b1;
            end
        endcase
    end

    logic [ADDR_W-1:0] target_p2;
    logic [ADDR_W-1:0] pc_next_p2;
    logic              wrap_p2;
    logic              illegal_p2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target_p2  <= '0;
            pc_next_p2 <= '0;
            wrap_p2    <= 1'b0;
            illegal_p2 <= 1'b0;
        end else if (s2_adv && vld_p1) begin
            target_p2  <= target_p1;
            pc_next_p2 <= pcn_p1;
            wrap_p2    <= wrap_p1;
            illegal_p2 <= illegal_p1;
        end
    end

    assign out_valid   = vld_p2;
    assign out_target  = target_p2;
    assign out_pc_next = pc_next_p2;
    assign out_wrap    = wrap_p2;
    assign out_illegal = illegal_p2;

endmodule

// File: tb/tb_branch_target_pipe.sv
// Bench for branch_target_pipe: directed vector table, handshake corner sequences,
// and randomized traffic scored against an arithmetic reference model.
module tb_branch_target_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_pc = '0;
    logic [25:0] in_imm = '0;
    logic [1:0]  in_mode = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_target;
    logic [31:0] out_pc_next;
    logic        out_wrap;
    logic        out_illegal;

    always #5 clk = ~clk;

    branch_target_pipe dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_pc      (in_pc),
        .in_imm     (in_imm),
        .in_mode    (in_mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_target (out_target),
        .out_pc_next(out_pc_next),
        .out_wrap   (out_wrap),
        .out_illegal(out_illegal)
    );

    typedef struct {
        logic [31:0] tgt;
        logic [31:0] pcn;
        logic        wrap;
        logic        ill;
    } res_t;

    typedef struct {
        logic [31:0] pc;
        logic [25:0] imm;
        logic [1:0]  mode;
        logic [31:0] tgt;
        logic [31:0] pcn;
        logic        wrap;
        logic        ill;
    } vec_t;

    res_t exp_q[$];
    res_t pending;
    int   total = 0;
    int   bad = 0;
    int   acc_cnt = 0;
    int   out_cnt = 0;

    // Reference: plain 64-bit arithmetic on the mathematical values.
    function automatic res_t model(input logic [31:0] pc, input logic [25:0] imm,
                                   input logic [1:0] mode);
        res_t    r;
        longint  modv;
        longint  pcn_full;
        longint  pcn;
        longint  off;
        longint  sum;
        logic [15:0] lo;
        modv     = 64'h1_0000_0000;
        pcn_full = longint'(pc) + 4;
        pcn      = pcn_full % modv;
        lo       = imm[15:0];
        off      = longint'($signed(lo)) * 4;
        r.pcn    = 32'(pcn);
        r.ill    = (mode == 2'b11);
        if (mode == 2'b00) begin
            sum    = pcn + off;
            r.wrap = (sum < 0) || (sum >= modv);
            r.tgt  = 32'(sum);
        end else if (mode == 2'b01) begin
            r.wrap = 1'b0;
            r.tgt  = 32'((pcn - (pcn % 64'h1000_0000)) + longint'(imm) * 4);
        end else begin
            r.wrap = (pcn_full >= modv);
            r.tgt  = 32'(pcn);
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    // One clock: score handshakes that happen at the coming edge, then advance.
    task automatic cycle();
        res_t e;
        #1;
        if (out_valid && out_ready) begin
            out_cnt++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result got=%h want=none", out_target);
            end else begin
                e = exp_q.pop_front();
                chk("target", out_target, e.tgt);
                chk("pc_next", out_pc_next, e.pcn);
                chk("wrap", 32'(out_wrap), 32'(e.wrap));
                chk("illegal", 32'(out_illegal), 32'(e.ill));
            end
        end
        if (in_valid && in_ready) begin
            exp_q.push_back(pending);
            acc_cnt++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_req(input logic [31:0] pc, input logic [25:0] imm, input logic [1:0] mode);
        in_pc    = pc;
        in_imm   = imm;
        in_mode  = mode;
        in_valid = 1'b1;
        pending  = model(pc, imm, mode);
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        in_pc     = v.pc;
        in_imm    = v.imm;
        in_mode   = v.mode;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        pending   = '{tgt: v.tgt, pcn: v.pcn, wrap: v.wrap, ill: v.ill};
        cycle();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 8) begin
            cycle();
            lat++;
        end
        chk("latency", 32'(lat), 32'd2);
        if (!out_valid) exp_q.delete();
        else cycle();
    endtask

    vec_t vecs[11];
    vec_t bp[4];

    initial begin
        int a0, o0, a1, n, idx;
        logic [31:0] snap_t, snap_p;
        logic snap_w, snap_i, have_snap, stable;

        vecs[0]  = '{32'h0040_0000, 26'h000_0003, 2'b00, 32'h0040_0010, 32'h0040_0004, 1'b0, 1'b0};
        vecs[1]  = '{32'h0040_0000, 26'h000_FFFF, 2'b00, 32'h0040_0000, 32'h0040_0004, 1'b0, 1'b0};
        vecs[2]  = '{32'hFFFF_FFF8, 26'h000_0002, 2'b00, 32'h0000_0004, 32'hFFFF_FFFC, 1'b1, 1'b0};
        vecs[3]  = '{32'h0000_0000, 26'h000_FFFE, 2'b00, 32'hFFFF_FFFC, 32'h0000_0004, 1'b1, 1'b0};
        vecs[4]  = '{32'h9000_0000, 26'h010_0004, 2'b01, 32'h9040_0010, 32'h9000_0004, 1'b0, 1'b0};
        vecs[5]  = '{32'h0000_0010, 26'h000_0000, 2'b11, 32'h0000_0014, 32'h0000_0014, 1'b0, 1'b1};
        vecs[6]  = '{32'hFFFF_FFFC, 26'h000_0000, 2'b10, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0};
        vecs[7]  = '{32'hFFFF_FFFC, 26'h000_0001, 2'b00, 32'h0000_0004, 32'h0000_0000, 1'b0, 1'b0};
        vecs[8]  = '{32'hFFFF_FFFC, 26'h3FF_FFFF, 2'b01, 32'h0FFF_FFFC, 32'h0000_0000, 1'b0, 1'b0};
        vecs[9]  = '{32'h0000_0100, 26'h3FF_0004, 2'b00, 32'h0000_0114, 32'h0000_0104, 1'b0, 1'b0};
        vecs[10] = '{32'h7FFF_FFF0, 26'h000_7FFF, 2'b00, 32'h8001_FFF0, 32'h7FFF_FFF4, 1'b0, 1'b0};

        bp[0] = '{32'h0000_1000, 26'h000_0010, 2'b00, '0, '0, 1'b0, 1'b0};
        bp[1] = '{32'h8000_0000, 26'h123_4567, 2'b01, '0, '0, 1'b0, 1'b0};
        bp[2] = '{32'hFFFF_FFFC, 26'h000_0000, 2'b10, '0, '0, 1'b0, 1'b0};
        bp[3] = '{32'h0000_0020, 26'h000_FFF0, 2'b11, '0, '0, 1'b0, 1'b0};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid_held", 32'(out_valid), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_target", out_target, 32'd0);
        chk("rst_pc_next", out_pc_next, 32'd0);
        chk("rst_wrap", 32'(out_wrap), 32'd0);
        chk("rst_illegal", 32'(out_illegal), 32'd0);

        // Directed vectors
        for (int i = 0; i < 11; i++) run_vec(vecs[i]);

        // Back-to-back stream
        out_ready = 1'b1;
        a0 = acc_cnt;
        o0 = out_cnt;
        for (int i = 0; i < 8; i++) begin
            set_req($urandom, 26'($urandom), 2'($urandom_range(0, 3)));
            cycle();
        end
        in_valid = 1'b0;
        chk("b2b_accepts", 32'(acc_cnt - a0), 32'd8);
        chk("b2b_outs_early", 32'(out_cnt - o0), 32'd6);
        cycle();
        cycle();
        chk("b2b_outs", 32'(out_cnt - o0), 32'd8);
        chk("b2b_idle", 32'(out_valid), 32'd0);

        // Backpressure: sink stalled while four requests are offered
        out_ready = 1'b0;
        a0 = acc_cnt;
        o0 = out_cnt;
        idx = 0;
        have_snap = 1'b0;
        stable = 1'b1;
        snap_t = '0; snap_p = '0; snap_w = 1'b0; snap_i = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (idx < 4) set_req(bp[idx].pc, bp[idx].imm, bp[idx].mode);
            else in_valid = 1'b0;
            a1 = acc_cnt;
            cycle();
            if (acc_cnt != a1) idx++;
            if (out_valid) begin
                if (!have_snap) begin
                    snap_t = out_target; snap_p = out_pc_next;
                    snap_w = out_wrap; snap_i = out_illegal;
                    have_snap = 1'b1;
                end else if (out_target !== snap_t || out_pc_next !== snap_p ||
                             out_wrap !== snap_w || out_illegal !== snap_i) begin
                    stable = 1'b0;
                end
            end else if (have_snap) begin
                stable = 1'b0;
            end
        end
        chk("bp_accepted", 32'(acc_cnt - a0), 32'd2);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_hold", 32'(stable & have_snap), 32'd1);
        chk("bp_no_out", 32'(out_cnt - o0), 32'd0);
        out_ready = 1'b1;
        n = 0;
        while ((idx < 4 || exp_q.size() != 0) && n < 20) begin
            if (idx < 4) set_req(bp[idx].pc, bp[idx].imm, bp[idx].mode);
            else in_valid = 1'b0;
            a1 = acc_cnt;
            cycle();
            if (acc_cnt != a1) idx++;
            n++;
        end
        in_valid = 1'b0;
        chk("bp_all_out", 32'(out_cnt - o0), 32'd4);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) != 0) begin
                if ($urandom_range(0, 5) == 0)
                    set_req(32'hFFFF_FFF0 | 32'($urandom_range(0, 15)), 26'($urandom),
                            2'($urandom_range(0, 3)));
                else
                    set_req($urandom, 26'($urandom), 2'($urandom_range(0, 3)));
            end else begin
                in_valid = 1'b0;
            end
            cycle();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 10) begin
            cycle();
            n++;
        end
        chk("rand_drain", 32'(exp_q.size()), 32'd0);

        // Reset with two requests in flight
        out_ready = 1'b0;
        set_req(32'h0000_2000, 26'h000_0001, 2'b00);
        cycle();
        set_req(32'h0000_3000, 26'h000_0002, 2'b10);
        cycle();
        in_valid = 1'b0;
        chk("rst2_pre_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst2_async_valid", 32'(out_valid), 32'd0);
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst2_in_ready", 32'(in_ready), 32'd1);
        chk("rst2_out_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        o0 = out_cnt;
        repeat (4) cycle();
        chk("rst2_no_stale", 32'(out_cnt - o0), 32'd0);
        run_vec(vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
